// File: rtl/mips_encoder_if.sv
// Request/response bundle between an instruction producer and the MIPS encoder.
// The producer drives in_* and out_ready; the encoder drives the rest.
interface mips_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        illegal;
    logic [15:0] enc_count;

    modport master (
        output in_valid,
        output in_kind,
        output in_rs,
        output in_rt,
        output in_rd,
        output in_imm,
        output in_target,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_instr,
        input  illegal,
        input  enc_count
    );

    modport slave (
        input  in_valid,
        input  in_kind,
        input  in_rs,
        input  in_rt,
        input  in_rd,
        input  in_imm,
        input  in_target,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_instr,
        output illegal,
        output enc_count
    );
endinterface

// File: rtl/mips_encoder.sv
// Encodes mnemonic/field requests into 32-bit MIPS words behind a 2-entry
// output FIFO; illegal kinds are consumed and flagged but never enqueued.
module mips_encoder (
    input  logic        clk,
    input  logic        reset,
    mips_encoder_if.slave bus
);

    logic [31:0] r_mem [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_occ;
    logic        r_armed;
    logic        r_illegal;
    logic [15:0] r_count;

    logic        w_accept;
    logic        w_pop;
    logic        w_push;
    logic        w_legal;
    logic [31:0] w_word;

    always_comb begin
        w_word  = '0;
        w_legal = 1'b1;
        unique case (bus.in_kind)
            4'd0:  w_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h20};
            4'd1:  w_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h22};
            4'd2:  w_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h24};
            4'd3:  w_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h25};
            4'd4:  w_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h2A};
            4'd5:  w_word = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd6:  w_word = {6'h2B, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd7:  w_word = {6'h04, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd8:  w_word = {6'h08, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd9:  w_word = {6'h09, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd10: w_word = {6'h02, bus.in_target};
            4'd11: w_word = {6'h0F, 5'd0, bus.in_rt, bus.in_imm};
            4'd12: w_word = {6'h0D, bus.in_rs, bus.in_rt, bus.in_imm};
            default: w_legal = 1'b0;
        endcase
    end

    // r_armed keeps in_ready low until the first edge out of reset
    assign bus.in_ready  = r_armed & (r_occ != 2'd2);
    assign bus.out_valid = (r_occ != 2'd0);
    assign bus.out_instr = bus.out_valid ? r_mem[r_rd_ptr] : 32'h0;
    assign bus.illegal   = r_illegal;
    assign bus.enc_count = r_count;

    assign w_accept = bus.in_valid & bus.in_ready;
    assign w_pop    = bus.out_valid & bus.out_ready;
    assign w_push   = w_accept & w_legal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem[0]  <= '0;
            r_mem[1]  <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_occ     <= 2'd0;
            r_armed   <= 1'b0;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else begin
            r_armed   <= 1'b1;
            r_illegal <= w_accept & ~w_legal;
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_word;
                r_wr_ptr        <= ~r_wr_ptr;
                if (r_count != 16'hFFFF) begin
                    r_count <= r_count + 16'd1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_mips_encoder.sv
// Bench for mips_encoder: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_mips_encoder;

    logic clk = 1'b0;
    logic reset;

    mips_encoder_if bus ();

    mips_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] m_q [$];
    int unsigned m_cnt   = 0;
    bit          m_ill   = 1'b0;
    bit          m_armed = 1'b0;

    localparam int unsigned FUNCT [5] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A};

    function automatic bit is_legal(input int unsigned kind);
        return kind <= 12;
    endfunction

    function automatic logic [31:0] ref_enc(
        input int unsigned kind, input int unsigned rs,
        input int unsigned rt, input int unsigned rd,
        input int unsigned imm, input int unsigned tgt);
        int unsigned op;
        if (kind <= 4)
            return (rs << 21) | (rt << 16) | (rd << 11) | FUNCT[kind];
        if (kind == 10)
            return (32'd2 << 26) | tgt;
        if (kind == 11)
            return (32'd15 << 26) | (rt << 16) | imm;
        case (kind)
            5:       op = 35;
            6:       op = 43;
            7:       op = 4;
            8:       op = 8;
            9:       op = 9;
            default: op = 13;
        endcase
        return (op << 26) | (rs << 21) | (rt << 16) | imm;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_clear();
        m_q.delete();
        m_cnt   = 0;
        m_ill   = 1'b0;
        m_armed = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":out_valid"}, 32'(bus.out_valid), 32'(m_q.size() > 0));
        chk({tag, ":out_instr"}, bus.out_instr,
            (m_q.size() > 0) ? m_q[0] : 32'h0);
        chk({tag, ":in_ready"}, 32'(bus.in_ready),
            32'(m_armed && m_q.size() < 2));
        chk({tag, ":illegal"}, 32'(bus.illegal), 32'(m_ill));
        chk({tag, ":enc_count"}, 32'(bus.enc_count), m_cnt);
    endtask

    task automatic drive(input bit v, input int unsigned kind,
                         input int unsigned rs, input int unsigned rt,
                         input int unsigned rd, input int unsigned imm,
                         input int unsigned tgt, input bit ordy);
        bus.in_valid  = v;
        bus.in_kind   = 4'(kind);
        bus.in_rs     = 5'(rs);
        bus.in_rt     = 5'(rt);
        bus.in_rd     = 5'(rd);
        bus.in_imm    = 16'(imm);
        bus.in_target = 26'(tgt);
        bus.out_ready = ordy;
    endtask

    // Advance one edge: decide accept/pop from model state, update, check.
    task automatic tick(input string tag);
        bit          acc;
        bit          pop;
        bit          legal;
        logic [31:0] w;
        acc   = bus.in_valid && m_armed && (m_q.size() < 2);
        pop   = bus.out_ready && (m_q.size() > 0);
        legal = is_legal(bus.in_kind);
        w     = ref_enc(bus.in_kind, bus.in_rs, bus.in_rt, bus.in_rd,
                        bus.in_imm, bus.in_target);
        @(posedge clk);
        if (!reset) begin
            model_clear();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (acc && legal) begin
                m_q.push_back(w);
                if (m_cnt != 32'hFFFF) m_cnt++;
            end
            m_ill   = acc && !legal;
            m_armed = 1'b1;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_clear();
        #1;
        check_all("reset_state");
        tick("in_reset0");
        tick("in_reset1");
        reset = 1'b1;
        tick("first_edge");
        chk("ready_after_reset", 32'(bus.in_ready), 32'd1);

        drive(1, 0, 1, 2, 3, 16'hFFFF, 26'h3FFFFFF, 1);
        tick("add");
        chk("add_word", bus.out_instr, 32'h00221820);
        chk("add_count", 32'(bus.enc_count), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick("add_drain");

        drive(1, 5, 29, 8, 7, 16'h0004, 26'h1234567, 1);
        tick("lw");
        chk("lw_word", bus.out_instr, 32'h8FA80004);
        drive(1, 10, 31, 31, 31, 16'hAAAA, 26'h0100000, 1);
        tick("j");
        chk("j_word", bus.out_instr, 32'h08100000);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick("j_drain");

        drive(1, 11, 5, 1, 9, 16'h1234, 0, 0);
        tick("lui");
        drive(1, 12, 0, 9, 3, 16'hBEEF, 0, 0);
        tick("ori");
        chk("full_not_ready", 32'(bus.in_ready), 32'd0);
        chk("lui_head", bus.out_instr, 32'h3C011234);
        drive(1, 0, 4, 4, 4, 0, 0, 0);
        tick("full_hold");
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick("pop_lui");
        chk("ori_head", bus.out_instr, 32'h3409BEEF);
        chk("ready_after_pop", 32'(bus.in_ready), 32'd1);
        tick("pop_ori");

        drive(1, 14, 1, 2, 3, 16'h5555, 0, 1);
        tick("illegal");
        chk("illegal_pulse", 32'(bus.illegal), 32'd1);
        chk("illegal_no_word", 32'(bus.out_valid), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick("illegal_end");
        chk("illegal_cleared", 32'(bus.illegal), 32'd0);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15),
                  $urandom, $urandom, $urandom, $urandom, $urandom,
                  $urandom_range(0, 2) != 0);
            tick("random");
        end

        drive(1, 1, 7, 8, 9, 0, 0, 0);
        tick("fill0");
        drive(1, 8, 3, 4, 0, 16'h8000, 0, 0);
        tick("fill1");
        chk("filled", 32'(bus.in_ready), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check_all("async_reset");
        tick("held_reset");
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick("release");
        chk("no_stale_word", 32'(bus.out_valid), 32'd0);
        tick("release2");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
